// File: rtl/sim_inst_mem_responder.sv
// Simulation instruction-memory slave for the ir_addr/ir_data channels: in-order queue, fixed latency.
// Define COPPERV_SIM_RANDOM_STALL_EN to add LFSR-driven stalls on both handshakes.
module sim_inst_mem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int LATENCY     = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ir_addr_valid,
    output logic                  ir_addr_ready,
    input  logic [ADDR_WIDTH-1:0] ir_addr,
    output logic                  ir_data_valid,
    input  logic                  ir_data_ready,
    output logic [DATA_WIDTH-1:0] ir_data,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  misalign_err
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CD_W  = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(QUEUE_DEPTH);
    localparam logic [CD_W-1:0]  CD_INIT = CD_W'(LATENCY);

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] w;
        w = a >> 2;
        return w[IDX_W-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem    [MEM_WORDS];
    logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
    logic [CD_W-1:0]       q_cd   [QUEUE_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  reset_q;
    logic                  head_ready;
    logic                  push, pop;

    assign head_ready = (count != '0) && (q_cd[rd_ptr] == '0);

`ifdef COPPERV_SIM_RANDOM_STALL_EN
    logic [15:0] lfsr;
    logic        shown;

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr  <= LFSR_SEED;
            shown <= 1'b0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            // Once a head has been presented it stays valid until taken.
            if (pop)
                shown <= 1'b0;
            else if (ir_data_valid)
                shown <= 1'b1;
        end
    end

    assign ir_addr_ready = !reset_q && (count < FULL) && lfsr[0];
    assign ir_data_valid = head_ready && (lfsr[1] || shown);
`else
    assign ir_addr_ready = !reset_q && (count < FULL);
    assign ir_data_valid = head_ready;
`endif

    assign push    = ir_addr_valid && ir_addr_ready;
    assign pop     = ir_data_valid && ir_data_ready;
    assign ir_data = ir_data_valid ? q_data[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        reset_q <= reset;
        if (reset) begin
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= push && (ir_addr[1:0] != 2'b00);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Loaded with LATENCY because the accepting edge is the first cycle of
    // the wait: valid rises after edge N+LATENCY.
    always_ff @(posedge clock) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (q_cd[i] != '0)
                q_cd[i] <= q_cd[i] - 1'b1;
        end
        if (push) begin
            q_cd[wr_ptr]   <= CD_INIT;
            q_data[wr_ptr] <= mem[word_index(ir_addr)];
        end
    end

    // Backdoor writes are the only writer, so a same-edge fetch sees the old word.
    always_ff @(posedge clock) begin
        if (load_en)
            mem[word_index(load_addr)] <= load_data;
    end

endmodule

// File: tb/tb_sim_inst_mem_responder.sv
// Directed self-checking bench for sim_inst_mem_responder with default parameters.
module tb_sim_inst_mem_responder;
    logic        clock = 1'b0;
    logic        reset;
    logic        ir_addr_valid;
    logic        ir_addr_ready;
    logic [31:0] ir_addr;
    logic        ir_data_valid;
    logic        ir_data_ready;
    logic [31:0] ir_data;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        misalign_err;

    int tests = 0;
    int fails = 0;

    logic [31:0] words [5];

    sim_inst_mem_responder dut (
        .clock(clock), .reset(reset),
        .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
        .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .misalign_err(misalign_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (ir_addr_ready !== 1'b0 || ir_data_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold[%0d]: ready=%b valid=%b expected 0 0", i, ir_addr_ready, ir_data_valid);
            end
        end
        reset = 1'b0;
        tests++;
        if (ir_addr_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_first: ready=%b expected 0", ir_addr_ready);
        end
        tick();
        tests++;
        if (ir_addr_ready !== 1'b1 || ir_data_valid !== 1'b0 || ir_data !== 32'h0 || misalign_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_second: ready=%b valid=%b data=%h err=%b expected 1 0 00000000 0",
                     ir_addr_ready, ir_data_valid, ir_data, misalign_err);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 5; i++) begin
            load_en   = 1'b1;
            load_addr = 32'(i * 4);
            load_data = words[i];
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic test_single_fetch();
        ir_data_ready = 1'b1;
        ir_addr_valid = 1'b1;
        ir_addr       = 32'h0;
        tick();
        ir_addr_valid = 1'b0;
        tests++;
        if (ir_data_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_n0: valid=%b expected 0", ir_data_valid);
        end
        tick();
        tests++;
        if (ir_data_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_n1: valid=%b expected 0", ir_data_valid);
        end
        tick();
        tests++;
        if (ir_data_valid !== 1'b1 || ir_data !== 32'h00000013) begin
            fails++;
            $display("FAIL single_n2: valid=%b data=%h expected 1 00000013", ir_data_valid, ir_data);
        end
        tick();
        tests++;
        if (ir_data_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_pop: valid=%b expected 0", ir_data_valid);
        end
    endtask

    task automatic test_back_to_back();
        ir_data_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ir_addr_valid = 1'b1;
            ir_addr       = 32'(i * 4);
            tests++;
            if (ir_addr_ready !== 1'b1) begin
                fails++;
                $display("FAIL fill_ready[%0d]: ready=%b expected 1", i, ir_addr_ready);
            end
            tick();
        end
        tests++;
        if (ir_addr_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_ready: ready=%b expected 0", ir_addr_ready);
        end
        ir_addr = 32'h10;
        tick();
        tests++;
        if (ir_addr_ready !== 1'b0) begin
            fails++;
            $display("FAIL fifth_stall: ready=%b expected 0", ir_addr_ready);
        end
        ir_addr_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (ir_data_valid !== 1'b1 || ir_data !== 32'h00000013 || ir_addr_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold[%0d]: valid=%b data=%h ready=%b expected 1 00000013 0",
                         i, ir_data_valid, ir_data, ir_addr_ready);
            end
            tick();
        end
        ir_data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (ir_data_valid !== 1'b1 || ir_data !== words[i]) begin
                fails++;
                $display("FAIL drain[%0d]: valid=%b data=%h expected 1 %h", i, ir_data_valid, ir_data, words[i]);
            end
            tick();
            if (i == 0) begin
                tests++;
                if (ir_addr_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL drain_ready: ready=%b expected 1", ir_addr_ready);
                end
            end
        end
        tests++;
        if (ir_data_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_empty: valid=%b expected 0", ir_data_valid);
        end
    endtask

    task automatic test_throughput();
        ir_data_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ir_addr_valid = (k < 6);
            ir_addr       = 32'((k % 4) * 4);
            tick();
            tests++;
            if (k >= 2) begin
                if (ir_data_valid !== 1'b1 || ir_data !== words[(k - 2) % 4] || ir_addr_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL stream[%0d]: valid=%b data=%h ready=%b expected 1 %h 1",
                             k, ir_data_valid, ir_data, ir_addr_ready, words[(k - 2) % 4]);
                end
            end else if (ir_data_valid !== 1'b0) begin
                fails++;
                $display("FAIL stream[%0d]: valid=%b expected 0", k, ir_data_valid);
            end
        end
        ir_addr_valid = 1'b0;
        tick();
        tests++;
        if (ir_data_valid !== 1'b0) begin
            fails++;
            $display("FAIL stream_end: valid=%b expected 0", ir_data_valid);
        end
    endtask

    task automatic test_misalign();
        ir_data_ready = 1'b1;
        ir_addr_valid = 1'b1;
        ir_addr       = 32'h1002;
        tick();
        ir_addr_valid = 1'b0;
        tests++;
        if (misalign_err !== 1'b1) begin
            fails++;
            $display("FAIL misalign_pulse: err=%b expected 1", misalign_err);
        end
        tick();
        tests++;
        if (misalign_err !== 1'b0 || ir_data_valid !== 1'b0) begin
            fails++;
            $display("FAIL misalign_clear: err=%b valid=%b expected 0 0", misalign_err, ir_data_valid);
        end
        tick();
        tests++;
        if (ir_data_valid !== 1'b1 || ir_data !== 32'h00000013 || misalign_err !== 1'b0) begin
            fails++;
            $display("FAIL misalign_data: valid=%b data=%h err=%b expected 1 00000013 0",
                     ir_data_valid, ir_data, misalign_err);
        end
        tick();
    endtask

    task automatic test_load_collision();
        ir_data_ready = 1'b1;
        ir_addr_valid = 1'b1;
        ir_addr       = 32'h8;
        load_en       = 1'b1;
        load_addr     = 32'h8;
        load_data     = 32'hDEADBEEF;
        tick();
        ir_addr_valid = 1'b0;
        load_en       = 1'b0;
        tick();
        tick();
        tests++;
        if (ir_data_valid !== 1'b1 || ir_data !== 32'h00100113) begin
            fails++;
            $display("FAIL collide_old: valid=%b data=%h expected 1 00100113", ir_data_valid, ir_data);
        end
        ir_addr_valid = 1'b1;
        tick();
        ir_addr_valid = 1'b0;
        tick();
        tick();
        tests++;
        if (ir_data_valid !== 1'b1 || ir_data !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL collide_new: valid=%b data=%h expected 1 deadbeef", ir_data_valid, ir_data);
        end
        tick();
    endtask

    task automatic test_reset_flush();
        ir_data_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ir_addr_valid = 1'b1;
            ir_addr       = 32'(i * 4);
            tick();
        end
        ir_addr_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ir_data_ready = 1'b1;
        tests++;
        if (ir_data_valid !== 1'b0 || ir_addr_ready !== 1'b0 || ir_data !== 32'h0) begin
            fails++;
            $display("FAIL flush_reset: valid=%b ready=%b data=%h expected 0 0 00000000",
                     ir_data_valid, ir_addr_ready, ir_data);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (ir_data_valid !== 1'b0 || ir_addr_ready !== 1'b1) begin
                fails++;
                $display("FAIL flush_quiet[%0d]: valid=%b ready=%b expected 0 1", i, ir_data_valid, ir_addr_ready);
            end
        end
        ir_addr_valid = 1'b1;
        ir_addr       = 32'h4;
        tick();
        ir_addr_valid = 1'b0;
        tick();
        tick();
        tests++;
        if (ir_data_valid !== 1'b1 || ir_data !== 32'h00500093) begin
            fails++;
            $display("FAIL flush_retain: valid=%b data=%h expected 1 00500093", ir_data_valid, ir_data);
        end
        tick();
        tests++;
        if (ir_data_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_single: valid=%b expected 0", ir_data_valid);
        end
    endtask

    initial begin
        words[0] = 32'h00000013;
        words[1] = 32'h00500093;
        words[2] = 32'h00100113;
        words[3] = 32'h002081b3;
        words[4] = 32'h40000033;
        reset         = 1'b1;
        ir_addr_valid = 1'b0;
        ir_addr       = '0;
        ir_data_ready = 1'b0;
        load_en       = 1'b0;
        load_addr     = '0;
        load_data     = '0;

        test_reset();
        preload();
        test_single_fetch();
        test_back_to_back();
        test_backpressure();
        test_throughput();
        test_misalign();
        test_load_collision();
        test_reset_flush();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
